// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - pipeline stage register with skid buffer, flush and perf counters

// Saturating event counter: clears on reset or clr, holds at all-ones.
module pipe_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  // count events, never wrapping past all-ones
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// Stage register: main register M feeds the next stage, skid register S
// catches the one word that may arrive while M is held, so in_ready can be
// a pure register output.
module pipe_stage_reg #(
  parameter int                 WIDTH     = 64,
  parameter logic [WIDTH-1:0]   NOP_VALUE = {WIDTH{1'b0}},
  parameter int                 CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             stall,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic             s_valid;
  logic [WIDTH-1:0] s_data;
  logic             accept;
  logic             m_free;

  // in_ready comes straight from the skid flag; S empty means room for a word
  assign in_ready = !s_valid;
  assign accept   = in_valid & in_ready;
  // M can take a new word when it is consumed this cycle or holds a bubble
  assign m_free   = !out_valid | !stall;

  // main and skid register update; flush overrides stall and drops any accept
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= NOP_VALUE;
      s_valid   <= 1'b0;
      s_data    <= NOP_VALUE;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_data  <= NOP_VALUE;
      s_valid   <= 1'b0;
      s_data    <= NOP_VALUE;
    end else if (m_free) begin
      if (s_valid) begin
        // skid drains first so ordering is preserved
        out_valid <= 1'b1;
        out_data  <= s_data;
        s_valid   <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
        out_data  <= in_data;
      end else begin
        out_valid <= 1'b0;
        out_data  <= NOP_VALUE;
      end
    end else if (accept) begin
      // M held by stall: park the incoming word in S
      s_valid <= 1'b1;
      s_data  <= in_data;
    end
  end

  pipe_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr_cnt),
    .inc (out_valid & stall),
    .cnt (stall_cnt)
  );

  pipe_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr_cnt),
    .inc (flush),
    .cnt (flush_cnt)
  );

  pipe_sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr_cnt),
    .inc (!out_valid & !flush),
    .cnt (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed self-checking bench for pipe_stage_reg
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        stall;
  logic        in_valid;
  logic [63:0] in_data;
  logic        clr_cnt;

  logic        ir, ov;
  logic [63:0] od;
  logic [15:0] sc, fc, bc;

  logic        ir4, ov4;
  logic [63:0] od4;
  logic [3:0]  sc4, fc4, bc4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_stage_reg dut (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_data(in_data), .in_ready(ir),
    .out_valid(ov), .out_data(od), .clr_cnt(clr_cnt),
    .stall_cnt(sc), .flush_cnt(fc), .bubble_cnt(bc)
  );

  pipe_stage_reg #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_data(in_data), .in_ready(ir4),
    .out_valid(ov4), .out_data(od4), .clr_cnt(clr_cnt),
    .stall_cnt(sc4), .flush_cnt(fc4), .bubble_cnt(bc4)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] d, input logic st, input logic fl);
    in_valid = v;
    in_data  = d;
    stall    = st;
    flush    = fl;
  endtask

  initial begin
    rst = 1'b0; clr_cnt = 1'b0;
    drive(1'b0, 64'h0, 1'b0, 1'b0);

    // 1: reset
    step(); step();
    chk("rst_ov", {63'b0, ov}, 64'd0);
    chk("rst_od", od, 64'd0);
    chk("rst_ir", {63'b0, ir}, 64'd1);
    chk("rst_cnt", {16'b0, sc, fc, bc}, 64'd0);
    chk("rst_cnt4", {52'b0, sc4, fc4, bc4}, 64'd0);
    rst = 1'b1;
    step();
    chk("idle_bc", {48'b0, bc}, 64'd1);

    // 2: streaming 1..5
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 64'(i), 1'b0, 1'b0);
      step();
      chk($sformatf("strm_od%0d", i), od, 64'(i));
      chk($sformatf("strm_ov%0d", i), {63'b0, ov}, 64'd1);
      chk($sformatf("strm_ir%0d", i), {63'b0, ir}, 64'd1);
    end
    chk("strm_bc", {48'b0, bc}, 64'd2);
    drive(1'b0, 64'h0, 1'b0, 1'b0);
    step();
    chk("strm_end_ov", {63'b0, ov}, 64'd0);
    chk("strm_end_od", od, 64'd0);

    // 3: skid
    drive(1'b1, 64'hA, 1'b0, 1'b0);
    step();
    chk("skid_a", od, 64'hA);
    drive(1'b1, 64'hB, 1'b1, 1'b0);
    step();
    chk("skid_hold_a", od, 64'hA);
    chk("skid_ir0", {63'b0, ir}, 64'd0);
    drive(1'b1, 64'hC, 1'b1, 1'b0);
    step();
    chk("skid_hold2", od, 64'hA);
    chk("skid_ir0b", {63'b0, ir}, 64'd0);
    step();
    chk("skid_hold3", od, 64'hA);
    chk("skid_sc", {48'b0, sc}, 64'd3);
    drive(1'b1, 64'hC, 1'b0, 1'b0);
    step();
    chk("skid_b", od, 64'hB);
    chk("skid_ir1", {63'b0, ir}, 64'd1);
    step();
    chk("skid_c", od, 64'hC);
    drive(1'b1, 64'hD, 1'b0, 1'b0);
    step();
    chk("skid_d", od, 64'hD);
    drive(1'b0, 64'h0, 1'b0, 1'b0);
    step();
    chk("skid_end_ov", {63'b0, ov}, 64'd0);
    chk("skid_sc_final", {48'b0, sc}, 64'd3);

    // stall on a bubble does not block loading M
    drive(1'b1, 64'h66, 1'b1, 1'b0);
    step();
    chk("bub_stall_od", od, 64'h66);
    chk("bub_stall_ir", {63'b0, ir}, 64'd1);
    drive(1'b0, 64'h0, 1'b0, 1'b0);
    step();

    // 4: flush beats stall with M and S full
    drive(1'b1, 64'h11, 1'b0, 1'b0);
    step();
    drive(1'b1, 64'h22, 1'b1, 1'b0);
    step();
    chk("fl_pre_ir", {63'b0, ir}, 64'd0);
    chk("fl_pre_od", od, 64'h11);
    drive(1'b1, 64'h33, 1'b1, 1'b1);
    step();
    chk("fl_ov", {63'b0, ov}, 64'd0);
    chk("fl_od", od, 64'd0);
    chk("fl_ir", {63'b0, ir}, 64'd1);
    chk("fl_fc", {48'b0, fc}, 64'd1);
    drive(1'b0, 64'h0, 1'b0, 1'b0);
    step();
    chk("fl_post_ov", {63'b0, ov}, 64'd0);
    chk("fl_post_od", od, 64'd0);

    // flush drops a word accepted in the same cycle
    drive(1'b1, 64'h77, 1'b0, 1'b1);
    step();
    chk("fl_acc_ov", {63'b0, ov}, 64'd0);
    chk("fl_acc_fc", {48'b0, fc}, 64'd2);
    drive(1'b0, 64'h0, 1'b0, 1'b0);
    step();
    chk("fl_acc_post", {63'b0, ov}, 64'd0);

    // 5: saturation on the 4-bit instance
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    chk("clr_bc4", {60'b0, bc4}, 64'd0);
    chk("clr_bc", {48'b0, bc}, 64'd0);
    repeat (20) step();
    chk("sat_bc4", {60'b0, bc4}, 64'd15);
    chk("sat_bc", {48'b0, bc}, 64'd20);
    step();
    chk("sat_bc4_hold", {60'b0, bc4}, 64'd15);
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    chk("sat_clr_bc4", {60'b0, bc4}, 64'd0);
    chk("sat_clr_fc4", {60'b0, fc4}, 64'd0);

    // 6: reset while stalled with S full
    drive(1'b1, 64'h44, 1'b0, 1'b0);
    step();
    drive(1'b1, 64'h55, 1'b1, 1'b0);
    step();
    chk("rs_pre_ir", {63'b0, ir4}, 64'd0);
    chk("rs_pre_sc4", {60'b0, sc4}, 64'd1);
    drive(1'b1, 64'h88, 1'b1, 1'b0);
    rst = 1'b0;
    step();
    chk("rs_ov", {63'b0, ov}, 64'd0);
    chk("rs_ir", {63'b0, ir}, 64'd1);
    chk("rs_od4", od4, 64'd0);
    rst = 1'b1;
    drive(1'b0, 64'h0, 1'b0, 1'b0);
    step();
    chk("rs_post_ov", {63'b0, ov}, 64'd0);
    chk("rs_post_od", od, 64'd0);
    chk("rs_post_ov4", {63'b0, ov4}, 64'd0);
    step();
    chk("rs_post2_ov", {63'b0, ov}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
